// File: rtl/next_pc_unit.sv
// Next-address generator: picks the PC target from sequential, branch, jump, call and return
// sources, with a return-address stack. Define RAS_WRAP_EN to make the stack circular on overflow.
module next_pc_unit #(
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     Init,
    input  logic [15:0]              Count,
    input  logic                     Halt,
    input  logic                     Branch,
    input  logic                     Taken,
    input  logic [15:0]              Offset,
    input  logic                     Jump,
    input  logic                     Call,
    input  logic                     Return,
    input  logic [15:0]              JumpAddr,
    output logic [15:0]              Target,
    output logic [$clog2(DEPTH):0]   RasDepth,
    output logic                     Underflow,
    output logic                     Overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_DEPTH = DEPTH[AW:0];
    localparam logic [AW:0]   DEPTH_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE    = 1;

    // ptr_q is the next free slot; the top entry lives at ptr_q-1 (modulo DEPTH).
    logic [15:0]   ras_q [DEPTH];
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   depth_q, depth_d;
    logic          uf_q, uf_d;
    logic          of_q, of_d;

    logic [15:0]   seq;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] wr_idx;
    logic          wr_en;
    logic          empty;
    logic          full;

    assign seq     = Count + 16'd1;
    assign top_idx = ptr_q - PTR_ONE;
    assign empty   = (depth_q == '0);
    assign full    = (depth_q == FULL_DEPTH);

    always_comb begin
        Target = seq;
        if (Init) begin
            Target = 16'h0000;
        end else if (Halt) begin
            Target = Count;
        end else if (Return && Call) begin
            // Replace, or a plain call when the stack is empty.
            Target = JumpAddr;
        end else if (Return) begin
            Target = empty ? seq : ras_q[top_idx];
        end else if (Call || Jump) begin
            Target = JumpAddr;
        end else if (Branch && Taken) begin
            Target = seq + Offset;
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        depth_d = depth_q;
        uf_d    = uf_q;
        of_d    = of_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        if (!Halt) begin
            if (Call && Return && !empty) begin
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end else if (Call) begin
                if (!full) begin
                    wr_en   = 1'b1;
                    ptr_d   = ptr_q + PTR_ONE;
                    depth_d = depth_q + DEPTH_ONE;
                end else begin
                    of_d = 1'b1;
`ifdef RAS_WRAP_EN
                    // When full, ptr_q points at the oldest entry, so a push overwrites it.
                    wr_en = 1'b1;
                    ptr_d = ptr_q + PTR_ONE;
`endif
                end
            end else if (Return) begin
                if (empty) begin
                    uf_d = 1'b1;
                end else begin
                    ptr_d   = top_idx;
                    depth_d = depth_q - DEPTH_ONE;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Init) begin
            // NOTE: the stack entries are cleared on reset because they must read as zero afterwards.
            for (int i = 0; i < DEPTH; i++) begin
                ras_q[i] <= '0;
            end
            ptr_q   <= '0;
            depth_q <= '0;
            uf_q    <= 1'b0;
            of_q    <= 1'b0;
        end else begin
            if (wr_en) begin
                ras_q[wr_idx] <= seq;
            end
            ptr_q   <= ptr_d;
            depth_q <= depth_d;
            uf_q    <= uf_d;
            of_q    <= of_d;
        end
    end

    assign RasDepth  = depth_q;
    assign Underflow = uf_q;
    assign Overflow  = of_q;
endmodule

// File: tb/tb_next_pc_unit.sv
// Table-driven bench for next_pc_unit plus hand sequences for RAS overflow, wrap and mid-chain reset.
module tb_next_pc_unit;
    localparam int DEPTH = 8;

    logic        CLK = 1'b0;
    logic        Init, Halt, Branch, Taken, Jump, Call, Return;
    logic [15:0] Count, Offset, JumpAddr;
    logic [15:0] Target;
    logic [3:0]  RasDepth;
    logic        Underflow, Overflow;

    int checks   = 0;
    int failures = 0;

    next_pc_unit #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .Init(Init), .Count(Count), .Halt(Halt), .Branch(Branch),
        .Taken(Taken), .Offset(Offset), .Jump(Jump), .Call(Call), .Return(Return),
        .JumpAddr(JumpAddr), .Target(Target), .RasDepth(RasDepth),
        .Underflow(Underflow), .Overflow(Overflow)
    );

    always #5 CLK = ~CLK;

    // Field order: init halt br tk jmp call ret count offset jaddr | target depth uf of
    typedef struct {
        logic        init, halt, br, tk, jmp, call, ret;
        logic [15:0] count, offset, jaddr;
        logic [15:0] exp_target;
        logic [3:0]  exp_depth;
        logic        exp_uf, exp_of;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic init, halt, br, tk, jmp, call, ret,
                         input logic [15:0] count, offset, jaddr);
        Init = init; Halt = halt; Branch = br; Taken = tk; Jump = jmp;
        Call = call; Return = ret; Count = count; Offset = offset; JumpAddr = jaddr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
    endtask

    task automatic do_init();
        @(negedge CLK);
        drive(1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        vecs[0]  = '{0,0,0,0,0,0,0, 16'h0010, 16'h0000, 16'h0000, 16'h0011, 4'd0, 0, 0};
        vecs[1]  = '{0,0,0,0,0,0,0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 4'd0, 0, 0};
        vecs[2]  = '{0,0,1,1,0,0,0, 16'h0020, 16'hFFFC, 16'h0000, 16'h001D, 4'd0, 0, 0};
        vecs[3]  = '{0,0,1,0,0,0,0, 16'h0020, 16'hFFFC, 16'h0000, 16'h0021, 4'd0, 0, 0};
        vecs[4]  = '{0,0,0,0,1,0,0, 16'h0005, 16'h0000, 16'h1234, 16'h1234, 4'd0, 0, 0};
        vecs[5]  = '{0,0,1,1,1,0,0, 16'h0005, 16'h0010, 16'h2345, 16'h2345, 4'd0, 0, 0};
        vecs[6]  = '{0,0,0,0,0,1,0, 16'h0005, 16'h0000, 16'h0100, 16'h0100, 4'd1, 0, 0};
        vecs[7]  = '{0,0,0,0,0,0,1, 16'h0107, 16'h0000, 16'h0000, 16'h0006, 4'd0, 0, 0};
        vecs[8]  = '{0,0,0,0,0,1,0, 16'h0010, 16'h0000, 16'h0200, 16'h0200, 4'd1, 0, 0};
        vecs[9]  = '{0,0,0,0,0,1,1, 16'h0020, 16'h0000, 16'h0300, 16'h0300, 4'd1, 0, 0};
        vecs[10] = '{0,1,0,0,0,1,0, 16'h0030, 16'h0000, 16'h0500, 16'h0030, 4'd1, 0, 0};
        vecs[11] = '{0,1,0,0,0,0,1, 16'h0031, 16'h0000, 16'h0000, 16'h0031, 4'd1, 0, 0};
        vecs[12] = '{0,0,1,1,1,0,1, 16'h0050, 16'h0008, 16'h0999, 16'h0021, 4'd0, 0, 0};
        vecs[13] = '{0,0,0,0,0,0,1, 16'h0040, 16'h0000, 16'h0000, 16'h0041, 4'd0, 1, 0};
        vecs[14] = '{0,0,0,0,0,0,0, 16'h0060, 16'h0000, 16'h0000, 16'h0061, 4'd0, 1, 0};
        vecs[15] = '{0,0,0,0,0,1,1, 16'h0070, 16'h0000, 16'h0400, 16'h0400, 4'd1, 1, 0};
        vecs[16] = '{0,0,0,0,0,0,1, 16'h0000, 16'h0000, 16'h0000, 16'h0071, 4'd0, 1, 0};
        vecs[17] = '{1,0,0,0,0,1,0, 16'h0080, 16'h0000, 16'h0600, 16'h0000, 4'd0, 0, 0};

        idle();
        Init = 1'b1;
        #1;
        check("reset_target", 32'(Target), 32'h0000);
        @(posedge CLK);
        #1;
        check("reset_depth", 32'(RasDepth), 32'd0);
        check("reset_uf", 32'(Underflow), 32'd0);
        check("reset_of", 32'(Overflow), 32'd0);

        for (int i = 0; i < 18; i++) begin
            @(negedge CLK);
            drive(vecs[i].init, vecs[i].halt, vecs[i].br, vecs[i].tk, vecs[i].jmp,
                  vecs[i].call, vecs[i].ret, vecs[i].count, vecs[i].offset, vecs[i].jaddr);
            #1;
            check($sformatf("vec%0d_target", i), 32'(Target), 32'(vecs[i].exp_target));
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d_depth", i), 32'(RasDepth), 32'(vecs[i].exp_depth));
            check($sformatf("vec%0d_uf", i), 32'(Underflow), 32'(vecs[i].exp_uf));
            check($sformatf("vec%0d_of", i), 32'(Overflow), 32'(vecs[i].exp_of));
        end

        // DEPTH+1 nested calls, then unwind.
        do_init();
        for (int k = 1; k <= DEPTH + 1; k++) begin
            @(negedge CLK);
            drive(0, 0, 0, 0, 0, 1, 0, 16'(k), 16'h0000, 16'(16'h1000 + k));
            #1;
            check($sformatf("nest%0d_target", k), 32'(Target), 32'(16'h1000 + k));
            @(posedge CLK);
            #1;
            check($sformatf("nest%0d_depth", k), 32'(RasDepth), 32'((k > DEPTH) ? DEPTH : k));
            check($sformatf("nest%0d_of", k), 32'(Overflow), 32'(k > DEPTH));
        end
        for (int i = 0; i < DEPTH; i++) begin
            logic [15:0] exp_ret;
`ifdef RAS_WRAP_EN
            exp_ret = 16'(10 - i);
`else
            exp_ret = 16'(9 - i);
`endif
            @(negedge CLK);
            drive(0, 0, 0, 0, 0, 0, 1, 16'(16'h0100 + i), 16'h0000, 16'h0000);
            #1;
            check($sformatf("unwind%0d_target", i), 32'(Target), 32'(exp_ret));
            @(posedge CLK);
            #1;
            check($sformatf("unwind%0d_depth", i), 32'(RasDepth), 32'(DEPTH - 1 - i));
        end
        check("of_sticky", 32'(Overflow), 32'd1);
        check("uf_after_unwind", 32'(Underflow), 32'd0);

        // Init mid-chain discards entries and ignores the simultaneous Return.
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            drive(0, 0, 0, 0, 0, 1, 0, 16'(16'h0200 + k), 16'h0000, 16'h0300);
            @(posedge CLK);
        end
        #1;
        check("chain_depth", 32'(RasDepth), 32'd2);
        @(negedge CLK);
        drive(1, 0, 0, 0, 0, 0, 1, 16'h0210, 16'h0000, 16'h0000);
        #1;
        check("midinit_target", 32'(Target), 32'h0000);
        @(posedge CLK);
        #1;
        check("midinit_depth", 32'(RasDepth), 32'd0);
        check("midinit_of", 32'(Overflow), 32'd0);
        @(negedge CLK);
        drive(0, 0, 0, 0, 0, 0, 1, 16'h0220, 16'h0000, 16'h0000);
        #1;
        check("post_init_ret_target", 32'(Target), 32'h0221);
        @(posedge CLK);
        #1;
        check("post_init_ret_uf", 32'(Underflow), 32'd1);
        check("post_init_ret_depth", 32'(RasDepth), 32'd0);

        @(negedge CLK);
        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/next_pc_unit.md
# next_pc_unit

Next-address generator for the single-cycle CPU. It sits directly upstream of the program counter and drives the counter's `Target` input every cycle. `Target` is chosen from sequential, branch, jump, call or return sources. Call/return addresses are held in an internal return-address stack (RAS), with sticky fault flags for stack misuse.

## Interface
Parameters:
- DEPTH, 8, number of RAS entries (power of two, 2..64)

Ports:
- CLK  in  1  system clock; all state updates on posedge
- Init  in  1  synchronous, active-high reset
- Count  in  16  current PC value (program counter output)
- Halt  in  1  processor halt; freezes all state
- Branch  in  1  conditional branch instruction
- Taken  in  1  branch condition result (qualified by Branch)
- Offset  in  16  two's-complement branch displacement, in words
- Jump  in  1  unconditional jump to JumpAddr
- Call  in  1  jump to JumpAddr and push return address
- Return  in  1  jump to popped return address
- JumpAddr  in  16  absolute jump/call destination
- Target  out  16  next PC value, registered by the program counter
- RasDepth  out  $clog2(DEPTH)+1  number of valid RAS entries
- Underflow  out  1  sticky: Return issued with empty RAS
- Overflow  out  1  sticky: Call issued with full RAS

## Operation
- Seq = Count + 1, modulo 2^16 (16'hFFFF -> 16'h0000).
- Target selection priority, highest first:
  1. Init -> 16'h0000
  2. Halt -> Count
  3. Return -> RAS top; if empty, Seq
  4. Call -> JumpAddr
  5. Jump -> JumpAddr
  6. Branch & Taken -> Seq + Offset, modulo 2^16
  7. otherwise -> Seq
- Call alone: push Seq onto the RAS and increment RasDepth.
- Return alone: pop the RAS and decrement RasDepth.
- Call and Return together (replace): Target = JumpAddr; top entry is overwritten with Seq; RasDepth unchanged.
  - If the RAS is empty, this behaves as a plain Call. Underflow is not set.
- Return with empty RAS: Target = Seq; Underflow set; RasDepth stays 0.
- Call with full RAS: governed by Configuration. Target = JumpAddr in both cases.
- Jump/Branch asserted together with Call/Return: lower priority is ignored.
- Underflow/Overflow clear only on Init.
- Halt: no push, pop, replace or flag update. Target = Count.

## Timing
- Target is combinational from Count and the control inputs. Latency is zero, so the PC registers it at the same CLK edge.
- RAS contents, RasDepth and flags update at posedge CLK only.
- Reset values at posedge with Init=1:
  - RasDepth = 0
  - Underflow = 0, Overflow = 0
  - all RAS entries = 16'h0000
  - Target = 16'h0000 while Init is high
- Init asserted mid-call-chain discards all entries in that cycle. Any Call/Return in the same cycle is ignored.
- A push is visible to a Return in the next cycle (RAS top = last pushed Seq).
- RasDepth ranges 0..DEPTH. Full is RasDepth == DEPTH; empty is RasDepth == 0.

## Configuration
- Macro `RAS_WRAP_EN`.
- Defined: RAS is circular. Call on full overwrites the oldest entry; the pushed Seq becomes top.
  - RasDepth stays DEPTH. Overflow is still set, to flag the lost entry.
- Undefined: Call on full does not modify the RAS. RasDepth stays DEPTH; Overflow is set.
  - The dropped return address is lost; the later Return pops the previous top.

## Test plan
- Init 1 cycle, then idle with Count=16'h0010 -> Target=16'h0011, RasDepth=0, flags 0. Count=16'hFFFF -> Target=16'h0000.
- Branch=1, Taken=1, Count=16'h0020, Offset=16'hFFFC -> Target=16'h001D. Same cycle with Taken=0 -> Target=16'h0021.
- Call JumpAddr=16'h0100 at Count=16'h0005, next cycle Return at Count=16'h0107:
  - first cycle: Target=16'h0100, then RasDepth=1
  - second cycle: Target=16'h0006, then RasDepth=0
- DEPTH+1 nested Calls at Count=1,2,...,9 (DEPTH=8):
  - Overflow=1 after the 9th Call; RasDepth=8.
  - 8 Returns then yield:
    - with RAS_WRAP_EN: 10,9,...,3
    - without: 9,8,...,2
- Return on empty RAS at Count=16'h0040 -> Target=16'h0041, Underflow=1 stays set. Next Init -> Underflow=0.
- Halt=1 with Call asserted at Count=16'h0030 -> Target=16'h0030; RasDepth unchanged across the edge; flags unchanged.
